// File: rtl/picorv32_mem_responder.sv
// picorv32_mem_responder: word-addressed RAM responder for the picorv32 native
// memory port, with bounded externally-chosen wait states, a handshake
// monitor and a completed-transaction counter.
//
// Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   mem_valid/instr/addr/wdata/wstrb  core request (wstrb == 0 means read)
//   stall_req                         request one more wait state this cycle
//   mem_ready, mem_rdata              registered response (one-cycle pulse)
//   oob                               sticky: captured address beyond RAM
//   proto_err                         sticky: core broke the handshake
//   xfer_cnt                          completed transactions, wrapping
module picorv32_mem_responder #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned MAX_WAIT  = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    input  logic        stall_req,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        oob,
    output logic        proto_err,
    output logic [31:0] xfer_cnt
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam logic [3:0]  MAX_WAIT_W = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        req_instr_q, req_instr_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [3:0]  req_wstrb_q, req_wstrb_d;
    logic        mem_ready_q, mem_ready_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        oob_q, oob_d;
    logic        proto_err_q, proto_err_d;
    logic [31:0] xfer_cnt_q, xfer_cnt_d;

    logic [31:0] mem [MEM_WORDS];
    logic [AW-1:0] idx;
    logic        mem_we;
    logic        req_changed;

    assign idx = req_addr_q[AW+1:2];

    // Core must hold a stable, valid request from capture through the response.
    assign req_changed = !mem_valid
                       || (mem_addr  != req_addr_q)
                       || (mem_wdata != req_wdata_q)
                       || (mem_wstrb != req_wstrb_q)
                       || (mem_instr != req_instr_q);

    // Next-state, response and monitor logic.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        req_instr_d = req_instr_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;
        mem_ready_d = 1'b0;
        mem_rdata_d = mem_rdata_q;
        oob_d       = oob_q;
        proto_err_d = proto_err_q;
        xfer_cnt_d  = xfer_cnt_q;
        mem_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    req_instr_d = mem_instr;
                    req_addr_d  = mem_addr;
                    req_wdata_d = mem_wdata;
                    req_wstrb_d = mem_wstrb;
                    wcnt_d      = 4'd0;
                    state_d     = S_WAIT;
                    if ((mem_addr >> (AW + 2)) != 32'd0) begin
                        oob_d = 1'b1;
                    end
                    if (mem_instr && (mem_wstrb != 4'd0)) begin
                        proto_err_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (req_changed) begin
                    proto_err_d = 1'b1;
                end
                if (stall_req && (wcnt_q < MAX_WAIT_W)) begin
                    wcnt_d = wcnt_q + 4'd1;
                end else begin
                    // Read-before-write: response carries the pre-write word.
                    state_d     = S_RESP;
                    mem_ready_d = 1'b1;
                    mem_rdata_d = mem[idx];
                    mem_we      = 1'b1;
                    xfer_cnt_d  = xfer_cnt_q + 32'd1;
                end
            end
            S_RESP: begin
                if (req_changed) begin
                    proto_err_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            wcnt_q      <= 4'd0;
            req_instr_q <= 1'b0;
            req_addr_q  <= 32'd0;
            req_wdata_q <= 32'd0;
            req_wstrb_q <= 4'd0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= 32'd0;
            oob_q       <= 1'b0;
            proto_err_q <= 1'b0;
            xfer_cnt_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            req_instr_q <= req_instr_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_wstrb_q <= req_wstrb_d;
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
            oob_q       <= oob_d;
            proto_err_q <= proto_err_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    // RAM contents survive reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (resetn && mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (req_wstrb_q[k]) begin
                    mem[idx][8*k +: 8] <= req_wdata_q[8*k +: 8];
                end
            end
        end
    end

    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign oob       = oob_q;
    assign proto_err = proto_err_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Bench for picorv32_mem_responder: transaction-level model of the RAM and
// response timing, checked every cycle, plus literal spot checks.
module tb_picorv32_mem_responder;

    localparam int unsigned MEM_WORDS = 1024;
    localparam int unsigned MAX_WAIT  = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_instr = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [3:0]  mem_wstrb = 4'd0;
    logic        stall_req = 1'b0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        oob;
    logic        proto_err;
    logic [31:0] xfer_cnt;

    picorv32_mem_responder #(
        .MEM_WORDS(MEM_WORDS),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .mem_valid(mem_valid),
        .mem_instr(mem_instr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .stall_req(stall_req),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .oob      (oob),
        .proto_err(proto_err),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0;
    int last_ready_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs for the current cycle, set by the driver just after each edge.
    logic        chk_en = 1'b0;
    logic        exp_ready = 1'b0;
    logic [31:0] exp_rdata = 32'd0;
    logic        exp_rdv = 1'b1;
    logic [31:0] exp_cnt = 32'd0;
    logic        exp_oob = 1'b0;
    logic        exp_perr = 1'b0;
    logic [31:0] ref_mem [int unsigned];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_ready", 32'(mem_ready), 32'(exp_ready));
            if (exp_rdv) chk("mem_rdata", mem_rdata, exp_rdata);
            chk("xfer_cnt", xfer_cnt, exp_cnt);
            chk("oob", 32'(oob), 32'(exp_oob));
            chk("proto_err", 32'(proto_err), 32'(exp_perr));
            if (mem_ready === 1'b1) last_ready_cyc = cyc;
        end
    end

    task automatic set_reset_exp();
        exp_ready = 1'b0;
        exp_rdata = 32'd0;
        exp_rdv   = 1'b1;
        exp_cnt   = 32'd0;
        exp_oob   = 1'b0;
        exp_perr  = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        resetn = 1'b0; mem_valid = 1'b0; stall_req = 1'b0; mem_wstrb = 4'd0;
        @(posedge clk); #1;
        resetn = 1'b1;
        set_reset_exp();
    endtask

    // One transaction; stall_req held for the first nstall wait cycles.
    // inject: 1 = drop mem_valid in the first wait cycle, 2 = perturb mem_addr there.
    task automatic xact(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int nstall, input int inject);
        int w;
        int unsigned widx;
        logic known;
        logic [31:0] old_w, new_w;
        w = (nstall > int'(MAX_WAIT)) ? int'(MAX_WAIT) : nstall;
        widx = (addr >> 2) % MEM_WORDS;
        known = ref_mem.exists(widx);
        old_w = known ? ref_mem[widx] : 32'd0;
        new_w = old_w;
        for (int k = 0; k < 4; k++) if (wstrb[k]) new_w[8*k +: 8] = wdata[8*k +: 8];

        @(posedge clk); #1;
        start_cyc = cyc;
        mem_valid = 1'b1; mem_instr = instr; mem_addr = addr;
        mem_wdata = wdata; mem_wstrb = wstrb; stall_req = 1'b0;
        for (int k = 1; k <= 2 + w; k++) begin
            @(posedge clk); #1;
            stall_req = (k - 1 < nstall);
            if (k == 1) begin
                if (addr >= MEM_WORDS * 4) exp_oob = 1'b1;
                if (instr && (wstrb != 4'd0)) exp_perr = 1'b1;
                if (inject == 1) mem_valid = 1'b0;
                if (inject == 2) mem_addr = addr ^ 32'h4;
            end
            if (k == 2) begin
                mem_valid = 1'b1;
                mem_addr  = addr;
                if (inject != 0) exp_perr = 1'b1;
            end
            if (k == 2 + w) begin
                exp_ready = 1'b1;
                exp_rdata = old_w;
                exp_rdv   = known;
                exp_cnt   = exp_cnt + 32'd1;
                if (known) ref_mem[widx] = new_w;
                else if (wstrb == 4'hF) ref_mem[widx] = wdata;
            end
        end
        @(posedge clk); #1;
        mem_valid = 1'b0; stall_req = 1'b0; mem_wstrb = 4'd0;
        exp_ready = 1'b0;
    endtask

    // Full-word write aborted by reset during its first wait cycle.
    task automatic xact_reset(input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = addr;
        mem_wdata = wdata; mem_wstrb = 4'hF; stall_req = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1; mem_valid = 1'b0; mem_wstrb = 4'd0;
        set_reset_exp();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;
        set_reset_exp();
        chk_en = 1'b1;
        idle(1);
        chk("reset xfer_cnt", xfer_cnt, 32'd0);
        chk("reset mem_rdata", mem_rdata, 32'd0);

        // Preload words 4 and 0, then read word 4 with no stall.
        xact(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
        xact(1'b0, 32'h00, 32'h11223344, 4'hF, 0, 0);
        xact(1'b0, 32'h10, 32'h0, 4'h0, 0, 0);
        chk("read latency", 32'(last_ready_cyc - start_cyc), 32'd2);
        chk("read data", mem_rdata, 32'hDEADBEEF);
        chk("count after 3", xfer_cnt, 32'd3);

        // Stall held high: capped at MAX_WAIT; single stall cycle.
        xact(1'b0, 32'h10, 32'h0, 4'h0, 5, 0);
        chk("capped stall latency", 32'(last_ready_cyc - start_cyc), 32'd4);
        xact(1'b0, 32'h10, 32'h0, 4'h0, 1, 0);
        chk("one stall latency", 32'(last_ready_cyc - start_cyc), 32'd3);

        // Byte-strobed write returns the old word; read shows merged bytes.
        xact(1'b0, 32'h00, 32'hAABBCCDD, 4'b0101, 2, 0);
        chk("rbw data", mem_rdata, 32'h11223344);
        xact(1'b0, 32'h00, 32'h0, 4'h0, 0, 0);
        chk("merged data", mem_rdata, 32'h11BB33DD);

        // Out-of-range write wraps onto word 0.
        xact(1'b0, 32'h1000, 32'h5, 4'hF, 0, 0);
        chk("oob set", 32'(oob), 32'd1);
        xact(1'b0, 32'h00, 32'h0, 4'h0, 1, 0);
        chk("wrapped data", mem_rdata, 32'h5);
        chk("count after 9", xfer_cnt, 32'd9);

        // Protocol violations, each from a clean reset.
        do_reset();
        xact(1'b0, 32'h10, 32'h0, 4'h0, 0, 1);
        idle(3);
        chk("perr valid drop sticky", 32'(proto_err), 32'd1);

        do_reset();
        xact(1'b0, 32'h10, 32'h0, 4'h0, 1, 2);
        chk("perr addr change", 32'(proto_err), 32'd1);

        do_reset();
        xact(1'b1, 32'h20, 32'h12345678, 4'hF, 0, 0);
        chk("perr fetch with wstrb", 32'(proto_err), 32'd1);

        // Reset during WAIT of a write: aborted, word untouched.
        do_reset();
        xact_reset(32'h10, 32'hFFFFFFFF);
        chk("abort ready", 32'(mem_ready), 32'd0);
        chk("abort count", xfer_cnt, 32'd0);
        idle(1);
        xact(1'b0, 32'h10, 32'h0, 4'h0, 0, 0);
        chk("abort word unchanged", mem_rdata, 32'hDEADBEEF);
        chk("count after abort", xfer_cnt, 32'd1);

        idle(2);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/picorv32_mem_responder.md
# picorv32_mem_responder

Synchronous memory responder for the picorv32 native memory interface, sitting directly downstream of the core's `mem_*` port in formal and simulation benches. It holds a word-addressed RAM, applies byte-strobed writes, returns read data, and inserts a bounded number of wait states chosen per cycle by an external `stall_req` input. The bound replaces the stall restriction a bench would otherwise write by hand. A built-in protocol monitor flags core-side handshake violations, and a transaction counter exposes progress for bounded checks.

## Interface
- `MEM_WORDS`, 1024: RAM depth in 32-bit words; power of two, ≥2; `AW = $clog2(MEM_WORDS)`.
- `MAX_WAIT`, 2: maximum wait states per transaction (0..15); 0 gives fixed minimum latency.
- `clk`  in  1  clock, all logic on rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `mem_valid`  in  1  request from core.
- `mem_instr`  in  1  request is an instruction fetch.
- `mem_addr`  in  32  byte address; bits [1:0] ignored.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte write enables; 0 = read.
- `stall_req`  in  1  environment request to insert a wait state this cycle (free solver input).
- `mem_ready`  out  1  transaction complete; registered.
- `mem_rdata`  out  32  read data; registered, valid while `mem_ready`=1.
- `oob`  out  1  sticky: a request addressed a word ≥ `MEM_WORDS`.
- `proto_err`  out  1  sticky: core violated the handshake.
- `xfer_cnt`  out  32  completed transactions, wrapping.

## Operation
- FSM states are IDLE, WAIT, and RESP; `wcnt` is a 4-bit wait counter.
- **IDLE**
  - If `mem_valid`=1: capture `{mem_instr, mem_addr, mem_wdata, mem_wstrb}`, clear `wcnt`, and go to WAIT.
  - Otherwise stay in IDLE.
- **WAIT**
  - If `stall_req`=1 and `wcnt` < `MAX_WAIT`: increment `wcnt` and stay in WAIT.
  - Otherwise go to RESP. On this edge:
    - Load `mem_rdata` with `mem[idx]`. This is the pre-write value: read-before-write.
    - Write each byte lane `k` whose captured `wstrb[k]`=1.
    - Increment `xfer_cnt`.
- **RESP**
  - `mem_ready`=1 for exactly this cycle; the next state is IDLE unconditionally.
  - A new `mem_valid` seen in RESP is not captured. It is captured in the following IDLE cycle.
- **Addressing**
  - `idx` = captured `mem_addr[AW+1:2]`; out-of-range addresses wrap.
  - `oob` is set when a captured `mem_addr[31:AW+2]` ≠ 0.
- **Protocol monitor.** `proto_err` is set, and stays set until reset, on any of these:
  - in WAIT or RESP, `mem_valid`=0;
  - in WAIT or RESP, any of `mem_addr`, `mem_wdata`, `mem_wstrb`, `mem_instr` differs from the captured value;
  - any captured request with `mem_instr`=1 and `mem_wstrb`≠0.
- **Memory contents**
  - RAM is not cleared by reset.
  - Writes are suppressed while `resetn`=0.

## Timing
- Reset values: state=IDLE, `wcnt`=0, `mem_ready`=0, `mem_rdata`=0, `oob`=0, `proto_err`=0, `xfer_cnt`=0. Reset has priority over every transition.
- Reset asserted in WAIT aborts the transaction: no write, no count. Reset asserted in RESP drops `mem_ready` on the next cycle.
- Latency: with `mem_valid` rising at cycle 0, `mem_ready`=1 at cycle 2+w, where w ∈ [0, `MAX_WAIT`] is the number of stall cycles granted. No request waits more than `MAX_WAIT`+2 cycles.
- `mem_ready` is never high for two consecutive cycles. `mem_ready` is never high unless a request was captured.
- `mem_rdata` holds its value until the next WAIT→RESP edge; it does not return to 0.
- Back-to-back throughput is at most one transaction every 3 cycles (core drops `mem_valid` after RESP; IDLE captures).
- Simultaneous events:
  - `stall_req`=1 with `wcnt`=`MAX_WAIT` → proceed to RESP; the stall is ignored.
  - A protocol violation during the RESP cycle is still flagged.
- `xfer_cnt` wraps from 0xFFFFFFFF to 0.

## Test plan
- **Reset and read latency:** preload `mem[4]`=0xDEADBEEF, `stall_req`=0, read at `mem_addr`=0x10 → `mem_ready` high only at cycle 2, `mem_rdata`=0xDEADBEEF, `xfer_cnt`=1.
- **Bounded stall:** `MAX_WAIT`=2, `stall_req` held 1 → ready at cycle 4 exactly; then `stall_req`=1,0 → ready at cycle 3.
- **Byte-strobed write:** write `mem_wdata`=0xAABBCCDD with `wstrb`=0b0101 to word 0 (old 0x11223344), then read word 0 → the write returns `mem_rdata`=0x11223344 (read-before-write); the read returns 0x11BB33DD.
- **Protocol violations:**
  - drop `mem_valid` in WAIT → `proto_err`=1 next cycle and sticky;
  - separate run, change `mem_addr` mid-WAIT → `proto_err`=1;
  - fetch with `wstrb`=0xF → `proto_err`=1.
- **Out of range:** `MEM_WORDS`=1024, write 0x5 at `mem_addr`=0x1000 → `oob`=1; the write lands in word 0; reading 0x0 returns 0x5.
- **Reset mid-operation:** `resetn`=0 during WAIT of a write → next cycle IDLE, `mem_ready`=0, target word unchanged, `xfer_cnt`=0.
